// File: rtl/qdr_req_arbiter.sv
// qdr_req_arbiter: round-robin share of one QDR controller master port between two requesters
// Ports:
//   qdr_clk, qdr_rst        clock, synchronous active-high reset
//   phy_rdy                 grants are held off while the PHY is not ready
//   err_clr                 pulse clearing proto_err/tag_err (a same-cycle error event wins)
//   reqN_*                  requester N command in (addr, wr/rd strobes, data, be), ack and read return out
//   qdr_*                   controller master side: registered command out, read data/valid in
//   rd_outstanding          reads issued and not yet returned
//   proto_err, tag_err      sticky error flags
module qdr_req_arbiter #(
   parameter int ADDR_W    = 21,
   parameter int DATA_W    = 72,
   parameter int BE_W      = 8,
   parameter int TAG_DEPTH = 16,
   parameter int TAG_AW    = 4
) (
   input  logic              qdr_clk,
   input  logic              qdr_rst,
   input  logic              phy_rdy,
   input  logic              err_clr,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_wr_strb,
   input  logic [DATA_W-1:0] req0_wr_data,
   input  logic [BE_W-1:0]   req0_wr_be,
   input  logic              req0_rd_strb,
   output logic              req0_ack,
   output logic [DATA_W-1:0] req0_rd_data,
   output logic              req0_rd_dvld,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_wr_strb,
   input  logic [DATA_W-1:0] req1_wr_data,
   input  logic [BE_W-1:0]   req1_wr_be,
   input  logic              req1_rd_strb,
   output logic              req1_ack,
   output logic [DATA_W-1:0] req1_rd_data,
   output logic              req1_rd_dvld,
   output logic [ADDR_W-1:0] qdr_addr,
   output logic              qdr_wr_strb,
   output logic [DATA_W-1:0] qdr_wr_data,
   output logic [BE_W-1:0]   qdr_wr_be,
   output logic              qdr_rd_strb,
   input  logic [DATA_W-1:0] qdr_rd_data,
   input  logic              qdr_rd_dvld,
   output logic [TAG_AW:0]   rd_outstanding,
   output logic              proto_err,
   output logic              tag_err
);
   localparam logic [TAG_AW:0] FULL_CNT = TAG_DEPTH[TAG_AW:0];
   logic [TAG_DEPTH-1:0] tag_mem;
   logic [TAG_AW-1:0]    wr_ptr, rd_ptr;
   logic [TAG_AW:0]      cnt;
   logic [DATA_W-1:0]    rd_q;
   logic                 last_gnt;
   logic                 full, empty, el0, el1, g0, g1, gnt, gwr, push, pop;
   always_comb begin
      full  = cnt == FULL_CNT;
      empty = cnt == '0;
      // a write is always eligible; a read only while a tag slot is free
      el0   = req0_wr_strb | (req0_rd_strb & ~full);
      el1   = req1_wr_strb | (req1_rd_strb & ~full);
      // last_gnt=1 means requester 1 won last, so requester 0 has priority
      g0    = phy_rdy & el0 & (~el1 | last_gnt);
      g1    = phy_rdy & el1 & (~el0 | ~last_gnt);
      gnt   = g0 | g1;
      // with both strobes up the write goes first and the read stays pending
      gwr   = g1 ? req1_wr_strb : req0_wr_strb;
      push  = gnt & ~gwr;
      pop   = qdr_rd_dvld & ~empty;
   end
   assign req0_ack       = g0;
   assign req1_ack       = g1;
   assign req0_rd_data   = rd_q;
   assign req1_rd_data   = rd_q;
   assign rd_outstanding = cnt;
   always_ff @(posedge qdr_clk) begin
      if (qdr_rst) begin
         last_gnt     <= 1'b1;
         qdr_addr     <= '0;
         qdr_wr_strb  <= 1'b0;
         qdr_wr_data  <= '0;
         qdr_wr_be    <= '0;
         qdr_rd_strb  <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt          <= '0;
         rd_q         <= '0;
         req0_rd_dvld <= 1'b0;
         req1_rd_dvld <= 1'b0;
         proto_err    <= 1'b0;
         tag_err      <= 1'b0;
      end else begin
         qdr_wr_strb  <= gnt & gwr;
         qdr_rd_strb  <= push;
         if (gnt) begin
            last_gnt    <= g1;
            qdr_addr    <= g1 ? req1_addr : req0_addr;
            qdr_wr_data <= g1 ? req1_wr_data : req0_wr_data;
            qdr_wr_be   <= g1 ? req1_wr_be : req0_wr_be;
         end
         if (push) begin
            tag_mem[wr_ptr] <= g1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         cnt          <= cnt + (TAG_AW+1)'(push) - (TAG_AW+1)'(pop);
         rd_q         <= qdr_rd_data;
         req0_rd_dvld <= pop & ~tag_mem[rd_ptr];
         req1_rd_dvld <= pop & tag_mem[rd_ptr];
         proto_err    <= (req0_wr_strb & req0_rd_strb) | (req1_wr_strb & req1_rd_strb) | (proto_err & ~err_clr);
         tag_err      <= (qdr_rd_dvld & empty) | (tag_err & ~err_clr);
      end
   end
endmodule

// File: tb/tb_qdr_req_arbiter.sv
// tb_qdr_req_arbiter: scoreboard bench for qdr_req_arbiter with a QDR read-return model
module tb_qdr_req_arbiter;
   localparam int AW = 21, DW = 72, BW = 8, TA = 4;
   logic qdr_clk = 0, qdr_rst = 1, phy_rdy = 0, err_clr = 0;
   logic [AW-1:0] req0_addr = '0, req1_addr = '0;
   logic req0_wr_strb = 0, req0_rd_strb = 0, req1_wr_strb = 0, req1_rd_strb = 0;
   logic [DW-1:0] req0_wr_data = '0, req1_wr_data = '0;
   logic [BW-1:0] req0_wr_be = '0, req1_wr_be = '0;
   logic [DW-1:0] qdr_rd_data = '0;
   logic qdr_rd_dvld = 0;
   logic req0_ack, req1_ack, req0_rd_dvld, req1_rd_dvld, qdr_wr_strb, qdr_rd_strb, proto_err, tag_err;
   logic [DW-1:0] req0_rd_data, req1_rd_data, qdr_wr_data;
   logic [AW-1:0] qdr_addr;
   logic [BW-1:0] qdr_wr_be;
   logic [TA:0] rd_outstanding;

   always #5 qdr_clk = ~qdr_clk;

   qdr_req_arbiter dut (
      .qdr_clk(qdr_clk), .qdr_rst(qdr_rst), .phy_rdy(phy_rdy), .err_clr(err_clr),
      .req0_addr(req0_addr), .req0_wr_strb(req0_wr_strb), .req0_wr_data(req0_wr_data),
      .req0_wr_be(req0_wr_be), .req0_rd_strb(req0_rd_strb), .req0_ack(req0_ack),
      .req0_rd_data(req0_rd_data), .req0_rd_dvld(req0_rd_dvld),
      .req1_addr(req1_addr), .req1_wr_strb(req1_wr_strb), .req1_wr_data(req1_wr_data),
      .req1_wr_be(req1_wr_be), .req1_rd_strb(req1_rd_strb), .req1_ack(req1_ack),
      .req1_rd_data(req1_rd_data), .req1_rd_dvld(req1_rd_dvld),
      .qdr_addr(qdr_addr), .qdr_wr_strb(qdr_wr_strb), .qdr_wr_data(qdr_wr_data),
      .qdr_wr_be(qdr_wr_be), .qdr_rd_strb(qdr_rd_strb), .qdr_rd_data(qdr_rd_data),
      .qdr_rd_dvld(qdr_rd_dvld), .rd_outstanding(rd_outstanding),
      .proto_err(proto_err), .tag_err(tag_err)
   );

   typedef struct packed {logic own; logic [DW-1:0] data;} exp_t;
   exp_t exq[$];
   logic [AW-1:0] pa[$];
   int pt[$];
   int ncmp = 0, nfail = 0, ncyc = 0, rel_req = 0, rel_done = 0;
   logic auto_ret = 0, frc = 0, prev_dvld = 0, a0 = 0, a1 = 0;
   logic [DW-1:0] frc_data = '0;

   function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
      return {3{3'b101, a}};
   endfunction

   // One clock: sample acks and push read expectations, check returns,
   // run the QDR memory model, then step to just after the next rising edge.
   task automatic cyc();
      exp_t e;
      @(negedge qdr_clk);
      a0 = req0_ack;
      a1 = req1_ack;
      if (a0 && req0_rd_strb && !req0_wr_strb) exq.push_back({1'b0, mdata(req0_addr)});
      if (a1 && req1_rd_strb && !req1_wr_strb) exq.push_back({1'b1, mdata(req1_addr)});
      if (req0_rd_dvld || req1_rd_dvld) begin
         ncmp++;
         if (exq.size() == 0) begin
            nfail++;
            $display("FAIL rd_ret: dvld0=%b dvld1=%b but no read expected", req0_rd_dvld, req1_rd_dvld);
         end else begin
            e = exq.pop_front();
            if (req0_rd_dvld !== ~e.own || req1_rd_dvld !== e.own || req0_rd_data !== e.data ||
                req1_rd_data !== e.data || prev_dvld !== 1'b1) begin
               nfail++;
               $display("FAIL rd_ret: got dvld0=%b dvld1=%b data0=%h data1=%h prev_qdr_dvld=%b, want owner %0d data %h",
                        req0_rd_dvld, req1_rd_dvld, req0_rd_data, req1_rd_data, prev_dvld, e.own, e.data);
            end
         end
      end
      ncyc++;
      if (qdr_rd_strb) begin
         pa.push_back(qdr_addr);
         pt.push_back(ncyc + 10);
      end
      qdr_rd_dvld = 0;
      qdr_rd_data = '0;
      if (frc) begin
         qdr_rd_dvld = 1;
         qdr_rd_data = frc_data;
         frc = 0;
      end else if (pa.size() > 0 && (auto_ret ? pt[0] <= ncyc : rel_req > rel_done)) begin
         qdr_rd_dvld = 1;
         qdr_rd_data = mdata(pa.pop_front());
         void'(pt.pop_front());
         if (!auto_ret) rel_done++;
      end
      prev_dvld = qdr_rd_dvld;
      @(posedge qdr_clk);
      #1;
   endtask

   task automatic do_reset();
      qdr_rst = 1;
      cyc();
      cyc();
      qdr_rst = 0;
      exq.delete();
   endtask

   task automatic test_reset();
      qdr_rst = 1;
      cyc();
      cyc();
      qdr_rst = 0;
      ncmp++;
      if ({qdr_wr_strb, qdr_rd_strb, req0_rd_dvld, req1_rd_dvld, proto_err, tag_err} !== 6'b0) begin
         nfail++;
         $display("FAIL reset_flags: got wr=%b rd=%b dv0=%b dv1=%b perr=%b terr=%b, want all 0",
                  qdr_wr_strb, qdr_rd_strb, req0_rd_dvld, req1_rd_dvld, proto_err, tag_err);
      end
      ncmp++;
      if (qdr_addr !== '0 || qdr_wr_data !== '0 || qdr_wr_be !== '0) begin
         nfail++;
         $display("FAIL reset_cmd: got addr=%h data=%h be=%h, want 0", qdr_addr, qdr_wr_data, qdr_wr_be);
      end
      ncmp++;
      if (rd_outstanding !== '0 || req0_rd_data !== '0 || req1_rd_data !== '0) begin
         nfail++;
         $display("FAIL reset_rd: got outstanding=%0d data0=%h data1=%h, want 0", rd_outstanding, req0_rd_data, req1_rd_data);
      end
   endtask

   task automatic test_phy_rdy();
      phy_rdy = 0;
      req0_addr = 21'h1abcd;
      req0_wr_data = 72'h12_3456_789a_bcde_f012;
      req0_wr_be = 8'ha5;
      req0_wr_strb = 1;
      cyc();
      ncmp++;
      if (a0 !== 1'b0 || a1 !== 1'b0) begin
         nfail++;
         $display("FAIL phy_hold_ack: got ack0=%b ack1=%b, want 0 0", a0, a1);
      end
      cyc();
      ncmp++;
      if (qdr_wr_strb !== 1'b0 || qdr_rd_strb !== 1'b0) begin
         nfail++;
         $display("FAIL phy_hold_strb: got wr=%b rd=%b, want 0 0", qdr_wr_strb, qdr_rd_strb);
      end
      phy_rdy = 1;
      cyc();
      req0_wr_strb = 0;
      ncmp++;
      if (a0 !== 1'b1) begin
         nfail++;
         $display("FAIL phy_ack: got ack0=%b, want 1", a0);
      end
      ncmp++;
      if (qdr_wr_strb !== 1'b1 || qdr_rd_strb !== 1'b0 || qdr_addr !== 21'h1abcd ||
          qdr_wr_data !== 72'h12_3456_789a_bcde_f012 || qdr_wr_be !== 8'ha5) begin
         nfail++;
         $display("FAIL wr_issue: got wr=%b rd=%b addr=%h data=%h be=%h, want 1 0 1abcd 123456789abcdef012 a5",
                  qdr_wr_strb, qdr_rd_strb, qdr_addr, qdr_wr_data, qdr_wr_be);
      end
      cyc();
      ncmp++;
      if (qdr_wr_strb !== 1'b0 || qdr_addr !== 21'h1abcd) begin
         nfail++;
         $display("FAIL wr_pulse: got wr=%b addr=%h, want 0 1abcd", qdr_wr_strb, qdr_addr);
      end
   endtask

   task automatic test_rr_reads();
      do_reset();
      auto_ret = 1;
      req0_addr = 21'h10;
      req1_addr = 21'h20;
      req0_rd_strb = 1;
      req1_rd_strb = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         ncmp++;
         if ({a0, a1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            nfail++;
            $display("FAIL rr_ack[%0d]: got ack0=%b ack1=%b, want %0d", i, a0, a1, i % 2);
         end
      end
      req0_rd_strb = 0;
      req1_rd_strb = 0;
      repeat (16) cyc();
      ncmp++;
      if (exq.size() != 0 || rd_outstanding !== '0) begin
         nfail++;
         $display("FAIL rr_drain: got %0d returns missing, outstanding=%0d, want 0 0", exq.size(), rd_outstanding);
      end
   endtask

   task automatic test_full();
      int n = 0;
      do_reset();
      auto_ret = 0;
      req0_addr = 21'h33;
      req0_rd_strb = 1;
      for (int i = 0; i < 16; i++) begin
         cyc();
         if (a0) n++;
      end
      ncmp++;
      if (n != 16 || rd_outstanding !== 5'd16) begin
         nfail++;
         $display("FAIL full_fill: got %0d acks outstanding=%0d, want 16 16", n, rd_outstanding);
      end
      cyc();
      ncmp++;
      if (a0 !== 1'b0) begin
         nfail++;
         $display("FAIL full_stall: got ack0=%b, want 0", a0);
      end
      req1_addr = 21'h55;
      req1_wr_strb = 1;
      cyc();
      req1_wr_strb = 0;
      ncmp++;
      if ({a0, a1} !== 2'b01) begin
         nfail++;
         $display("FAIL full_wr: got ack0=%b ack1=%b, want 0 1", a0, a1);
      end
      rel_req++;
      cyc();
      ncmp++;
      if (a0 !== 1'b0) begin
         nfail++;
         $display("FAIL full_pop_same: got ack0=%b, want 0", a0);
      end
      cyc();
      req0_rd_strb = 0;
      ncmp++;
      if (a0 !== 1'b1 || rd_outstanding !== 5'd16) begin
         nfail++;
         $display("FAIL full_resume: got ack0=%b outstanding=%0d, want 1 16", a0, rd_outstanding);
      end
      rel_req += 16;
      repeat (20) cyc();
      ncmp++;
      if (exq.size() != 0 || rd_outstanding !== '0) begin
         nfail++;
         $display("FAIL full_drain: got %0d returns missing, outstanding=%0d, want 0 0", exq.size(), rd_outstanding);
      end
   endtask

   task automatic test_proto();
      auto_ret = 1;
      req1_addr = 21'h44;
      req1_wr_data = 72'haa_5555_aaaa_5555_aaaa;
      req1_wr_be = 8'h3c;
      req1_wr_strb = 1;
      req1_rd_strb = 1;
      cyc();
      req1_wr_strb = 0;
      ncmp++;
      if (a1 !== 1'b1 || qdr_wr_strb !== 1'b1 || qdr_rd_strb !== 1'b0 || qdr_addr !== 21'h44 ||
          qdr_wr_data !== 72'haa_5555_aaaa_5555_aaaa || proto_err !== 1'b1 || rd_outstanding !== '0) begin
         nfail++;
         $display("FAIL proto_wr: got ack1=%b wr=%b rd=%b addr=%h data=%h perr=%b outst=%0d, want 1 1 0 44 aa5555aaaa5555aaaa 1 0",
                  a1, qdr_wr_strb, qdr_rd_strb, qdr_addr, qdr_wr_data, proto_err, rd_outstanding);
      end
      cyc();
      req1_rd_strb = 0;
      ncmp++;
      if (a1 !== 1'b1 || qdr_rd_strb !== 1'b1 || qdr_wr_strb !== 1'b0 || rd_outstanding !== 5'd1) begin
         nfail++;
         $display("FAIL proto_rd: got ack1=%b rd=%b wr=%b outst=%0d, want 1 1 0 1", a1, qdr_rd_strb, qdr_wr_strb, rd_outstanding);
      end
      err_clr = 1;
      cyc();
      err_clr = 0;
      ncmp++;
      if (proto_err !== 1'b0) begin
         nfail++;
         $display("FAIL proto_clr: got perr=%b, want 0", proto_err);
      end
      req0_wr_strb = 1;
      req0_rd_strb = 1;
      err_clr = 1;
      cyc();
      err_clr = 0;
      req0_wr_strb = 0;
      req0_rd_strb = 0;
      ncmp++;
      if (proto_err !== 1'b1) begin
         nfail++;
         $display("FAIL proto_set_wins: got perr=%b, want 1", proto_err);
      end
      err_clr = 1;
      cyc();
      err_clr = 0;
      repeat (14) cyc();
      ncmp++;
      if (proto_err !== 1'b0 || exq.size() != 0) begin
         nfail++;
         $display("FAIL proto_end: got perr=%b missing=%0d, want 0 0", proto_err, exq.size());
      end
   endtask

   task automatic test_tag_err();
      logic bad = 0;
      do_reset();
      auto_ret = 0;
      frc_data = 72'hde_adbe_efde_adbe_ef01;
      frc = 1;
      cyc();
      ncmp++;
      if (tag_err !== 1'b1 || req0_rd_dvld !== 1'b0 || req1_rd_dvld !== 1'b0 || rd_outstanding !== '0) begin
         nfail++;
         $display("FAIL tag_empty: got terr=%b dv0=%b dv1=%b outst=%0d, want 1 0 0 0",
                  tag_err, req0_rd_dvld, req1_rd_dvld, rd_outstanding);
      end
      err_clr = 1;
      cyc();
      err_clr = 0;
      ncmp++;
      if (tag_err !== 1'b0) begin
         nfail++;
         $display("FAIL tag_clr: got terr=%b, want 0", tag_err);
      end
      req0_addr = 21'h66;
      req0_rd_strb = 1;
      repeat (5) cyc();
      req0_rd_strb = 0;
      cyc();
      ncmp++;
      if (rd_outstanding !== 5'd5) begin
         nfail++;
         $display("FAIL tag_pre_rst: got outstanding=%0d, want 5", rd_outstanding);
      end
      qdr_rst = 1;
      cyc();
      qdr_rst = 0;
      exq.delete();
      ncmp++;
      if (rd_outstanding !== '0 || tag_err !== 1'b0) begin
         nfail++;
         $display("FAIL tag_rst: got outstanding=%0d terr=%b, want 0 0", rd_outstanding, tag_err);
      end
      rel_req += 5;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (rd_outstanding !== '0) bad = 1;
      end
      ncmp++;
      if (bad || tag_err !== 1'b1) begin
         nfail++;
         $display("FAIL tag_late: got outstanding_nonzero=%b terr=%b, want 0 1", bad, tag_err);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      auto_ret = 0;
      req0_addr = 21'h10;
      req0_rd_strb = 1;
      repeat (2) cyc();
      req0_rd_strb = 0;
      req1_addr = 21'h20;
      req1_rd_strb = 1;
      cyc();
      req1_rd_strb = 0;
      cyc();
      ncmp++;
      if (rd_outstanding !== 5'd3) begin
         nfail++;
         $display("FAIL pp_fill: got outstanding=%0d, want 3", rd_outstanding);
      end
      req1_rd_strb = 1;
      rel_req++;
      cyc();
      req1_rd_strb = 0;
      ncmp++;
      if (a1 !== 1'b1 || rd_outstanding !== 5'd3 || req0_rd_dvld !== 1'b1 || req1_rd_dvld !== 1'b0) begin
         nfail++;
         $display("FAIL pp_same: got ack1=%b outstanding=%0d dv0=%b dv1=%b, want 1 3 1 0",
                  a1, rd_outstanding, req0_rd_dvld, req1_rd_dvld);
      end
      rel_req += 3;
      repeat (8) cyc();
      ncmp++;
      if (rd_outstanding !== '0 || exq.size() != 0) begin
         nfail++;
         $display("FAIL pp_drain: got outstanding=%0d missing=%0d, want 0 0", rd_outstanding, exq.size());
      end
   endtask

   initial begin
      test_reset();
      test_phy_rdy();
      test_rr_reads();
      test_full();
      test_proto();
      test_tag_err();
      test_push_pop();
      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/qdr_req_arbiter.md
Name: qdr_req_arbiter

Overview:
- Shares one QDR controller master port (addr, wr/rd strobes, data, byte enables, rd_dvld return) between two user-side requesters.
- Sits between user logic and the QDR sniffer/controller master interface, in the qdr_clk domain.
- Round-robin arbitration issues at most one command per cycle and holds off grants until the PHY reports ready.
- An owner-tag FIFO routes each read return to the requester that issued the read.

Parameters:
- ADDR_W, 21, QDR word address width.
- DATA_W, 72, data width per command (2x36 burst).
- BE_W, 8, byte-enable width.
- TAG_DEPTH, 16, read-owner FIFO depth; power of 2; must be >= QDR read latency + 2.
- TAG_AW, 4, log2(TAG_DEPTH).

Ports:
- qdr_clk  in  1  single clock for the whole block.
- qdr_rst  in  1  synchronous, active-high reset.
- phy_rdy  in  1  QDR PHY calibrated/ready.
- err_clr  in  1  one-cycle pulse; clears the sticky error flags.
- reqN_addr  in  ADDR_W  requester N (N=0,1) address.
- reqN_wr_strb  in  1  write request; held until ack.
- reqN_wr_data  in  DATA_W  write data.
- reqN_wr_be  in  BE_W  write byte enables.
- reqN_rd_strb  in  1  read request; held until ack.
- reqN_ack  out  1  command accepted this cycle.
- reqN_rd_data  out  DATA_W  read return data.
- reqN_rd_dvld  out  1  read return valid for requester N.
- qdr_addr  out  ADDR_W  to controller master_addr.
- qdr_wr_strb  out  1  to master_wr_strb.
- qdr_wr_data  out  DATA_W  to master_wr_data.
- qdr_wr_be  out  BE_W  to master_wr_be.
- qdr_rd_strb  out  1  to master_rd_strb.
- qdr_rd_data  in  DATA_W  from master_rd_data.
- qdr_rd_dvld  in  1  from master_rd_dvld.
- rd_outstanding  out  TAG_AW+1  reads issued but not yet returned.
- proto_err  out  1  sticky: a requester asserted wr_strb and rd_strb together.
- tag_err  out  1  sticky: qdr_rd_dvld arrived with the tag FIFO empty.

Behaviour:
Reset:
- All qdr_* outputs, reqN_rd_dvld, reqN_rd_data, rd_outstanding and the error flags are 0.
- Tag FIFO is emptied.
- RR pointer selects requester 0 as first priority.
- Reset mid-operation discards all in-flight tags.

Pending requests:
- Requester N is pending when reqN_wr_strb | reqN_rd_strb.
- A pending read is eligible only if the tag FIFO is not full.
- A pending write is always eligible.

Grant:
- Evaluated combinationally each cycle, only when phy_rdy=1.
- If both requesters are eligible, the one not granted last wins. Otherwise the sole eligible requester wins.
- reqN_ack=1 in the grant cycle (combinational).
- The requester may drop or change its strobe in the next cycle.
- The RR pointer updates on every grant.

Command issue:
- Registered; the granted command appears on qdr_* one cycle after ack.
- qdr_wr_strb and qdr_rd_strb are single-cycle pulses and are never both 1.
- With no grant, both strobes are 0; addr/data hold their last values.

Both strobes from one requester:
- The write is issued; the read is not consumed by that ack.
- proto_err is set.
- The requester must re-present the read.

Read tag FIFO:
- On read issue (same edge qdr_rd_strb is registered), push the owner ID.
- On qdr_rd_dvld, pop the FIFO.
- Push and pop in the same cycle leave the count unchanged.
- rd_outstanding = FIFO count.

Read return:
- Latency is 1 cycle: qdr_rd_data is registered and broadcast to both reqN_rd_data.
- reqN_rd_dvld = registered dvld & (popped owner == N).

Boundary cases:
- dvld with an empty FIFO (including returns after reset): no dvld is forwarded and tag_err is set.
- FIFO full: reads stall (no ack); writes from either requester continue to be granted; the RR pointer advances only on actual grants.
- phy_rdy=0: no acks and no new strobes; in-flight reads still return and pop normally.
- err_clr: clears both flags. If an error event occurs in the same cycle, the flag is set (set wins).

Test Plan:
- Reset, then phy_rdy=0 with req0_wr_strb held -> no ack, qdr_wr_strb=0. Raise phy_rdy -> req0_ack at cycle t; qdr_wr_strb=1 with req0_addr/data/be at t+1.
- Both requesters hold rd_strb (req0 addr 0x10, req1 addr 0x20) for 4 grants -> acks alternate 0,1,0,1 starting with 0. Model returns dvld 10 cycles after each rd_strb -> rd_dvld alternates 0,1,0,1 with matching data, each 1 cycle after qdr_rd_dvld.
- req0 issues 16 reads with no returns (TAG_DEPTH=16) -> rd_outstanding=16, 17th read not acked. req1 write still acked. One return -> 17th read acked next cycle.
- req1 asserts wr_strb and rd_strb together -> write issued, proto_err=1, read issued on a later grant. err_clr pulse -> proto_err=0.
- qdr_rd_dvld with FIFO empty -> no reqN_rd_dvld, tag_err=1. Reset while 5 reads are outstanding, then 5 late returns -> tag_err=1, rd_outstanding stays 0.
- Simultaneous push and pop with rd_outstanding=3 -> stays 3. The owner of the return is the oldest tag.
